// File: rtl/ceespu_branch_resolver.sv
// Execute-stage branch resolver for the ceespu gshare predictor: in-order queue of
// predicted branches, predictor training strobe, mispredict flush/redirect and statistics.
module ceespu_branch_resolver #(
    parameter int QUEUE_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_push,
    input  logic [15:0] I_push_pc,
    input  logic        I_push_prediction,
    input  logic [1:0]  I_push_state,
    input  logic        I_resolve,
    input  logic        I_resolve_taken,
    input  logic [15:0] I_resolve_target,
    output logic        O_full,
    output logic        O_empty,
    output logic        update_table,
    output logic [15:0] branch_address,
    output logic [1:0]  branch_prediction_state,
    output logic        branch_taken,
    output logic        O_flush,
    output logic [15:0] O_redirect_pc,
    output logic [15:0] O_mispredict_count,
    output logic        O_error
);

    localparam int DEPTH = 1 << QUEUE_LOG2;
    localparam logic [QUEUE_LOG2:0]   DEPTH_C    = (QUEUE_LOG2+1)'(32'd1 << QUEUE_LOG2);
    localparam logic [QUEUE_LOG2:0]   CNT_ZERO_C = (QUEUE_LOG2+1)'(32'd0);
    localparam logic [QUEUE_LOG2:0]   CNT_ONE_C  = (QUEUE_LOG2+1)'(32'd1);
    localparam logic [QUEUE_LOG2-1:0] PTR_ZERO_C = QUEUE_LOG2'(32'd0);
    localparam logic [QUEUE_LOG2-1:0] PTR_ONE_C  = QUEUE_LOG2'(32'd1);
    localparam logic [15:0]           CNT_MAX_C  = 16'hFFFF;
    localparam logic [15:0]           PC_STEP_C  = 16'd4;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [15:0]           pc_mem_r    [DEPTH];
    logic [1:0]            state_mem_r [DEPTH];
    logic [DEPTH-1:0]      pred_mem_r;
    logic [QUEUE_LOG2-1:0] rd_ptr_r;
    logic [QUEUE_LOG2-1:0] wr_ptr_r;
    logic [QUEUE_LOG2:0]   count_r;
    logic [0:0]            fsm_r;

    logic                  full_r;
    logic                  empty_r;
    logic                  update_table_r;
    logic [15:0]           branch_address_r;
    logic [1:0]            branch_state_r;
    logic                  branch_taken_r;
    logic                  flush_r;
    logic [15:0]           redirect_pc_r;
    logic [15:0]           mispredict_count_r;
    logic                  error_r;

    logic                  in_run_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    logic                  pop_s;
    logic                  push_ok_s;
    logic                  mispredict_s;
    logic                  overflow_s;
    logic                  underflow_s;
    logic [15:0]           head_pc_s;
    logic [1:0]            head_state_s;
    logic                  head_pred_s;
    logic [15:0]           redirect_s;
    logic [QUEUE_LOG2:0]   count_next_s;
    logic [0:0]            fsm_next_s;

    assign head_pc_s    = pc_mem_r[rd_ptr_r];
    assign head_state_s = state_mem_r[rd_ptr_r];
    assign head_pred_s  = pred_mem_r[rd_ptr_r];

    // Queue handshake decode; a mispredict kills any same-cycle push because it is wrong-path.
    always_comb begin
        in_run_s     = (fsm_r == ST_RUN);
        q_full_s     = (count_r == DEPTH_C);
        q_empty_s    = (count_r == CNT_ZERO_C);
        pop_s        = in_run_s && I_resolve && !q_empty_s;
        mispredict_s = pop_s && (head_pred_s != I_resolve_taken);
        push_ok_s    = in_run_s && I_push && !mispredict_s && (!q_full_s || pop_s);
        overflow_s   = in_run_s && I_push && q_full_s && !pop_s;
        underflow_s  = in_run_s && I_resolve && q_empty_s;
        if (I_resolve_taken) begin
            redirect_s = I_resolve_target;
        end else begin
            redirect_s = head_pc_s + PC_STEP_C;
        end
    end

    // Occupancy after this edge; drives both the counter and the registered full/empty flags.
    always_comb begin
        count_next_s = count_r;
        if (mispredict_s) begin
            count_next_s = CNT_ZERO_C;
        end else begin
            case ({push_ok_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE_C;
                2'b01:   count_next_s = count_r - CNT_ONE_C;
                default: count_next_s = count_r;
            endcase
        end
    end

    // RUN/FLUSH sequencing: FLUSH is a single wrong-path blanking cycle.
    always_comb begin
        fsm_next_s = ST_RUN;
        case (fsm_r)
            ST_RUN: begin
                if (mispredict_s) begin
                    fsm_next_s = ST_FLUSH;
                end else begin
                    fsm_next_s = ST_RUN;
                end
            end
            ST_FLUSH: fsm_next_s = ST_RUN;
            default:  fsm_next_s = ST_RUN;
        endcase
    end

    // Queue entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 16'h0000;
                state_mem_r[i] <= 2'b00;
            end
            pred_mem_r <= {DEPTH{1'b0}};
        end else if (push_ok_s) begin
            pc_mem_r[wr_ptr_r]    <= I_push_pc;
            state_mem_r[wr_ptr_r] <= I_push_state;
            pred_mem_r[wr_ptr_r]  <= I_push_prediction;
        end
    end

    // Pointers, occupancy, FSM and the registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO_C;
            wr_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
            fsm_r    <= ST_RUN;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (mispredict_s) begin
                rd_ptr_r <= PTR_ZERO_C;
                wr_ptr_r <= PTR_ZERO_C;
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
                end
            end
            count_r <= count_next_s;
            fsm_r   <= fsm_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == CNT_ZERO_C);
        end
    end

    // Predictor training and mispredict redirect; payloads hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_table_r   <= 1'b0;
            branch_address_r <= 16'h0000;
            branch_state_r   <= 2'b00;
            branch_taken_r   <= 1'b0;
            flush_r          <= 1'b0;
            redirect_pc_r    <= 16'h0000;
        end else begin
            update_table_r <= pop_s;
            flush_r        <= mispredict_s;
            if (pop_s) begin
                branch_address_r <= head_pc_s;
                branch_state_r   <= head_state_s;
                branch_taken_r   <= I_resolve_taken;
            end
            if (mispredict_s) begin
                redirect_pc_r <= redirect_s;
            end
        end
    end

    // Saturating mispredict statistic and sticky overflow/underflow error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_count_r <= 16'h0000;
            error_r            <= 1'b0;
        end else begin
            if (mispredict_s && (mispredict_count_r != CNT_MAX_C)) begin
                mispredict_count_r <= mispredict_count_r + 16'd1;
            end
            if (overflow_s || underflow_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign O_full                  = full_r;
    assign O_empty                 = empty_r;
    assign update_table            = update_table_r;
    assign branch_address          = branch_address_r;
    assign branch_prediction_state = branch_state_r;
    assign branch_taken            = branch_taken_r;
    assign O_flush                 = flush_r;
    assign O_redirect_pc           = redirect_pc_r;
    assign O_mispredict_count      = mispredict_count_r;
    assign O_error                 = error_r;

endmodule

// File: tb/tb_ceespu_branch_resolver.sv
// Directed table-driven bench for ceespu_branch_resolver plus hand-written reset,
// underflow and counter-saturation sequences.
module tb_ceespu_branch_resolver;

    logic        clk;
    logic        rst;
    logic        I_push;
    logic [15:0] I_push_pc;
    logic        I_push_prediction;
    logic [1:0]  I_push_state;
    logic        I_resolve;
    logic        I_resolve_taken;
    logic [15:0] I_resolve_target;
    logic        O_full;
    logic        O_empty;
    logic        update_table;
    logic [15:0] branch_address;
    logic [1:0]  branch_prediction_state;
    logic        branch_taken;
    logic        O_flush;
    logic [15:0] O_redirect_pc;
    logic [15:0] O_mispredict_count;
    logic        O_error;

    int checks_total  = 0;
    int checks_passed = 0;

    ceespu_branch_resolver #(.QUEUE_LOG2(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .I_push                  (I_push),
        .I_push_pc               (I_push_pc),
        .I_push_prediction       (I_push_prediction),
        .I_push_state            (I_push_state),
        .I_resolve               (I_resolve),
        .I_resolve_taken         (I_resolve_taken),
        .I_resolve_target        (I_resolve_target),
        .O_full                  (O_full),
        .O_empty                 (O_empty),
        .update_table            (update_table),
        .branch_address          (branch_address),
        .branch_prediction_state (branch_prediction_state),
        .branch_taken            (branch_taken),
        .O_flush                 (O_flush),
        .O_redirect_pc           (O_redirect_pc),
        .O_mispredict_count      (O_mispredict_count),
        .O_error                 (O_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {upd, addr, state, taken, flush, redirect, full, empty, count, error}
    typedef struct {
        logic        push;
        logic [15:0] pc;
        logic        pred;
        logic [1:0]  st;
        logic        res;
        logic        tk;
        logic [15:0] tgt;
        logic [55:0] exp;
    } vec_t;

    localparam logic [55:0] RESET_EXP = {1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0000,
                                         1'b0, 1'b1, 16'h0000, 1'b0};

    vec_t vecs [25];

    function automatic vec_t mk(input logic p, input logic [15:0] pc, input logic pr,
                                input logic [1:0] st, input logic r, input logic tk,
                                input logic [15:0] tgt, input logic e_upd,
                                input logic [15:0] e_addr, input logic [1:0] e_st,
                                input logic e_tk, input logic e_fl, input logic [15:0] e_red,
                                input logic e_full, input logic e_empty,
                                input logic [15:0] e_cnt, input logic e_err);
        vec_t v;
        v.push = p; v.pc = pc; v.pred = pr; v.st = st;
        v.res = r; v.tk = tk; v.tgt = tgt;
        v.exp = {e_upd, e_addr, e_st, e_tk, e_fl, e_red, e_full, e_empty, e_cnt, e_err};
        return v;
    endfunction

    function automatic logic [55:0] outs();
        return {update_table, branch_address, branch_prediction_state, branch_taken,
                O_flush, O_redirect_pc, O_full, O_empty, O_mispredict_count, O_error};
    endfunction

    task automatic check(input string name, input logic [55:0] got, input logic [55:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic p, input logic [15:0] pc, input logic pr, input logic [1:0] st,
                       input logic r, input logic tk, input logic [15:0] tgt);
        I_push = p; I_push_pc = pc; I_push_prediction = pr; I_push_state = st;
        I_resolve = r; I_resolve_taken = tk; I_resolve_target = tgt;
        @(negedge clk);
    endtask

    initial begin
        //              push pc       pr st   res tk tgt        upd addr     st tk fl red      fu em cnt     err
        vecs[0]  = mk(1, 16'h0040, 1, 2'd3, 0, 0, 16'h0000, 0, 16'h0000, 2'd0, 0, 0, 16'h0000, 0, 0, 16'd0, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 2'd0, 1, 1, 16'h1234, 1, 16'h0040, 2'd3, 1, 0, 16'h0000, 0, 1, 16'd0, 0);
        vecs[2]  = mk(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0040, 2'd3, 1, 0, 16'h0000, 0, 1, 16'd0, 0);
        vecs[3]  = mk(1, 16'h0100, 1, 2'd2, 0, 0, 16'h0000, 0, 16'h0040, 2'd3, 1, 0, 16'h0000, 0, 0, 16'd0, 0);
        vecs[4]  = mk(1, 16'h0104, 0, 2'd1, 0, 0, 16'h0000, 0, 16'h0040, 2'd3, 1, 0, 16'h0000, 0, 0, 16'd0, 0);
        vecs[5]  = mk(0, 16'h0000, 0, 2'd0, 1, 0, 16'h0BAD, 1, 16'h0100, 2'd2, 0, 1, 16'h0104, 0, 1, 16'd1, 0);
        vecs[6]  = mk(1, 16'h0200, 1, 2'd0, 1, 1, 16'h0300, 0, 16'h0100, 2'd2, 0, 0, 16'h0104, 0, 1, 16'd1, 0);
        vecs[7]  = mk(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0100, 2'd2, 0, 0, 16'h0104, 0, 1, 16'd1, 0);
        vecs[8]  = mk(1, 16'hFFFC, 0, 2'd0, 0, 0, 16'h0000, 0, 16'h0100, 2'd2, 0, 0, 16'h0104, 0, 0, 16'd1, 0);
        vecs[9]  = mk(0, 16'h0000, 0, 2'd0, 1, 1, 16'h0200, 1, 16'hFFFC, 2'd0, 1, 1, 16'h0200, 0, 1, 16'd2, 0);
        vecs[10] = mk(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd0, 1, 0, 16'h0200, 0, 1, 16'd2, 0);
        vecs[11] = mk(1, 16'hFFFC, 1, 2'd3, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd0, 1, 0, 16'h0200, 0, 0, 16'd2, 0);
        vecs[12] = mk(0, 16'h0000, 0, 2'd0, 1, 0, 16'h5555, 1, 16'hFFFC, 2'd3, 0, 1, 16'h0000, 0, 1, 16'd3, 0);
        vecs[13] = mk(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd3, 0, 0, 16'h0000, 0, 1, 16'd3, 0);
        vecs[14] = mk(1, 16'h1000, 1, 2'd1, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd3, 0, 0, 16'h0000, 0, 0, 16'd3, 0);
        vecs[15] = mk(1, 16'h1004, 0, 2'd2, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd3, 0, 0, 16'h0000, 0, 0, 16'd3, 0);
        vecs[16] = mk(1, 16'h1008, 1, 2'd3, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd3, 0, 0, 16'h0000, 0, 0, 16'd3, 0);
        vecs[17] = mk(1, 16'h100C, 0, 2'd0, 0, 0, 16'h0000, 0, 16'hFFFC, 2'd3, 0, 0, 16'h0000, 1, 0, 16'd3, 0);
        vecs[18] = mk(1, 16'h1010, 1, 2'd1, 1, 1, 16'h0000, 1, 16'h1000, 2'd1, 1, 0, 16'h0000, 1, 0, 16'd3, 0);
        vecs[19] = mk(1, 16'h1014, 0, 2'd2, 0, 0, 16'h0000, 0, 16'h1000, 2'd1, 1, 0, 16'h0000, 1, 0, 16'd3, 1);
        vecs[20] = mk(0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 1, 16'h1004, 2'd2, 0, 0, 16'h0000, 0, 0, 16'd3, 1);
        vecs[21] = mk(0, 16'h0000, 0, 2'd0, 1, 1, 16'h0000, 1, 16'h1008, 2'd3, 1, 0, 16'h0000, 0, 0, 16'd3, 1);
        vecs[22] = mk(0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 1, 16'h100C, 2'd0, 0, 0, 16'h0000, 0, 0, 16'd3, 1);
        vecs[23] = mk(0, 16'h0000, 0, 2'd0, 1, 1, 16'h0000, 1, 16'h1010, 2'd1, 1, 0, 16'h0000, 0, 1, 16'd3, 1);
        vecs[24] = mk(0, 16'h0000, 0, 2'd0, 1, 1, 16'h0000, 0, 16'h1010, 2'd1, 1, 0, 16'h0000, 0, 1, 16'd3, 1);

        rst = 1'b1;
        I_push = 1'b0; I_push_pc = 16'h0000; I_push_prediction = 1'b0; I_push_state = 2'd0;
        I_resolve = 1'b0; I_resolve_taken = 1'b0; I_resolve_target = 16'h0000;
        @(negedge clk);
        check("reset_values", outs(), RESET_EXP);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].push, vecs[i].pc, vecs[i].pred, vecs[i].st,
                vecs[i].res, vecs[i].tk, vecs[i].tgt);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Underflow from a clean reset, then asynchronous reset with two entries queued.
        rst = 1'b1;
        cyc(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000);
        rst = 1'b0;
        cyc(0, 16'h0000, 0, 2'd0, 1, 1, 16'h0000);
        check("underflow", outs(), {1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0000,
                                    1'b0, 1'b1, 16'h0000, 1'b1});
        cyc(1, 16'h2000, 1, 2'd1, 0, 0, 16'h0000);
        cyc(1, 16'h2004, 0, 2'd2, 0, 0, 16'h0000);
        cyc(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000);
        check("two_queued_empty", {55'd0, O_empty}, {55'd0, 1'b0});
        #2 rst = 1'b1;
        #1 check("async_reset", outs(), RESET_EXP);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: preload the statistic just below the ceiling, then mispredict three times.
        force dut.mispredict_count_r = 16'hFFFE;
        #1 release dut.mispredict_count_r;
        @(negedge clk);
        check("sat_preload", {40'd0, O_mispredict_count}, {40'd0, 16'hFFFE});
        for (int k = 0; k < 3; k++) begin
            cyc(1, 16'h3000, 1, 2'd2, 0, 0, 16'h0000);
            cyc(0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000);
            check($sformatf("sat_flush%0d", k), {55'd0, O_flush}, {55'd0, 1'b1});
            check($sformatf("sat_count%0d", k), {40'd0, O_mispredict_count}, {40'd0, 16'hFFFF});
            cyc(0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
